// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for a multicycle RV32I core that shares one ALU and one unified
// instruction/data memory. It steps each instruction through FETCH, DECODE and
// the execute/memory/writeback states. It drives the datapath mux selects and
// the write enables for the PC, IR, register file and memory. Memory accesses
// stall on mem_ready.
//
// Optional feature (compile-time macro INSTRET_CNT_EN):
//   When defined, the output port instret[31:0] is added. It counts retired
//   instructions.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   opcode     in   instruction[6:0] from the instruction register
//   funct3     in   instruction[14:12]
//   zero       in   ALU zero flag
//   mem_ready  in   memory access completes this cycle
//   PCWrite    out  PC load enable
//   AdrSrc     out  memory address select (0 PC, 1 ALUOut)
//   MemWrite   out  memory write strobe
//   IRWrite    out  IR / OldPC load enable
//   ResultSrc  out  result mux (00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt)
//   ALUSrcA    out  ALU A mux (00 PC, 01 OldPC, 10 rs1)
//   ALUSrcB    out  ALU B mux (00 rs2, 01 ImmExt, 10 constant 4)
//   AluOp      out  00 add, 01 sub, 10 decode from funct
//   ImmSrc     out  immediate format, decoded combinationally from opcode
//   RegWrite   out  register file write enable
//   halted     out  sticky illegal-opcode flag
//   instret    out  retired-instruction counter (INSTRET_CNT_EN only)
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  AluOp,
    output logic [2:0]  ImmSrc,
    output logic        RegWrite,
`ifdef INSTRET_CNT_EN
    output logic [31:0] instret,
`endif
    output logic        halted
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = STATE_W'(4'd0),
        S_DECODE    = STATE_W'(4'd1),
        S_MEM_ADR   = STATE_W'(4'd2),
        S_MEM_READ  = STATE_W'(4'd3),
        S_MEM_WB    = STATE_W'(4'd4),
        S_MEM_WRITE = STATE_W'(4'd5),
        S_EXEC_R    = STATE_W'(4'd6),
        S_EXEC_I    = STATE_W'(4'd7),
        S_ALU_WB    = STATE_W'(4'd8),
        S_BRANCH    = STATE_W'(4'd9),
        S_JAL       = STATE_W'(4'd10),
        S_JALR      = STATE_W'(4'd11),
        S_JALR_PC   = STATE_W'(4'd12),
        S_LUI       = STATE_W'(4'd13),
        S_ERROR     = STATE_W'(4'd14)
    } state_t;

    state_t state_r;
    logic   pc_write_s;
    logic   mem_write_s;
    logic   ir_write_s;
    logic   reg_write_s;

`ifdef INSTRET_CNT_EN
    logic   retire_s;

    // An instruction retires on the cycle its final state hands back to FETCH.
    always_comb begin
        retire_s = 1'b0;
        case (state_r)
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_LUI: retire_s = 1'b1;
            S_MEM_WRITE:                         retire_s = mem_ready;
            default:                             retire_s = 1'b0;
        endcase
    end
`endif

    // State register, sticky halt flag and optional retirement counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
            halted  <= 1'b0;
`ifdef INSTRET_CNT_EN
            instret <= 32'd0;
`endif
        end else begin
            case (state_r)
                S_FETCH:     state_r <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_r <= S_MEM_ADR;
                        OP_R:              state_r <= S_EXEC_R;
                        OP_I:              state_r <= S_EXEC_I;
                        OP_BR:             state_r <= S_BRANCH;
                        OP_JAL:            state_r <= S_JAL;
                        OP_JALR:           state_r <= S_JALR;
                        OP_LUI:            state_r <= S_LUI;
                        default: begin
                            state_r <= S_ERROR;
                            halted  <= 1'b1;
                        end
                    endcase
                end
                S_MEM_ADR:   state_r <= (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  state_r <= mem_ready ? S_MEM_WB : S_MEM_READ;
                S_MEM_WB:    state_r <= S_FETCH;
                S_MEM_WRITE: state_r <= mem_ready ? S_FETCH : S_MEM_WRITE;
                S_EXEC_R:    state_r <= S_ALU_WB;
                S_EXEC_I:    state_r <= S_ALU_WB;
                S_ALU_WB:    state_r <= S_FETCH;
                S_BRANCH:    state_r <= S_FETCH;
                S_JAL:       state_r <= S_ALU_WB;
                S_JALR:      state_r <= S_JALR_PC;
                S_JALR_PC:   state_r <= S_ALU_WB;
                S_LUI:       state_r <= S_FETCH;
                // ERROR and any corrupted encoding lock up until reset.
                default: begin
                    state_r <= S_ERROR;
                    halted  <= 1'b1;
                end
            endcase
`ifdef INSTRET_CNT_EN
            if (retire_s) begin
                instret <= instret + 32'd1;
            end else begin
                instret <= instret;
            end
`endif
        end
    end

    // Moore decode of datapath controls. FETCH enables and the branch PC load
    // also look at the live mem_ready and zero inputs.
    always_comb begin
        pc_write_s  = 1'b0;
        AdrSrc      = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        AluOp       = 2'b00;
        reg_write_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                pc_write_s = mem_ready;
                ir_write_s = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEM_ADR, S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEM_READ:  AdrSrc = 1'b1;
            S_MEM_WB: begin
                ResultSrc   = 2'b01;
                reg_write_s = 1'b1;
            end
            S_MEM_WRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = 2'b10;
                AluOp   = 2'b10;
            end
            S_EXEC_I: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                AluOp   = 2'b10;
            end
            S_ALU_WB:    reg_write_s = 1'b1;
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                AluOp   = 2'b01;
                case (funct3)
                    3'b000:  pc_write_s = zero;
                    3'b001:  pc_write_s = ~zero;
                    default: pc_write_s = 1'b0;
                endcase
            end
            S_JAL, S_JALR_PC: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_write_s = 1'b1;
            end
            S_LUI: begin
                ResultSrc   = 2'b11;
                reg_write_s = 1'b1;
            end
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    // Holding rst_n low suppresses every enable, even when FETCH sees mem_ready.
    always_comb begin
        PCWrite  = pc_write_s  & rst_n;
        MemWrite = mem_write_s & rst_n;
        IRWrite  = ir_write_s  & rst_n;
        RegWrite = reg_write_s & rst_n;
    end

    // Immediate format select, decoded straight from the opcode.
    always_comb begin
        case (opcode)
            OP_STORE: ImmSrc = 3'b001;
            OP_BR:    ImmSrc = 3'b010;
            OP_LUI:   ImmSrc = 3'b011;
            OP_JAL:   ImmSrc = 3'b100;
            default:  ImmSrc = 3'b000;
        endcase
    end

endmodule
